// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// The LSU uses the slave modport; the core/memory environment uses master.
interface load_store_unit_if #(
    parameter int width = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [width-1:0] req_addr;
    logic [width-1:0] req_wdata;
    logic             resp_valid;
    logic [width-1:0] resp_rdata;
    logic             resp_err;
    logic [width-1:0] mem_addr;
    logic             mem_read;
    logic             mem_write;
    logic [width-1:0] mem_wdata;
    logic [width-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit on a word-wide memory with one-cycle registered read data.
// Define LSU_SUBWORD_EN to build byte/half accesses (lane extraction and store RMW).
module load_store_unit #(
    parameter int width = 32
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] CAP  = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    logic [1:0]       state;
    logic [width-1:2] word_addr_q;
    logic [width-1:0] wdata_q;
    logic             resp_valid_r;
    logic             resp_err_r;
    logic [width-1:0] resp_rdata_r;
    logic [width-1:0] mem_wdata_r;
    logic             accept;
    logic             req_err;
`ifdef LSU_SUBWORD_EN
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [1:0]       lo_q;
`endif

    function automatic logic access_err(input logic [2:0] f3, input logic [1:0] lo);
`ifdef LSU_SUBWORD_EN
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return lo[0];
            3'b010:         return lo != 2'b00;
            default:        return 1'b1;
        endcase
`else
        return (f3 != 3'b010) || (lo != 2'b00);
`endif
    endfunction

`ifdef LSU_SUBWORD_EN
    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] lo);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'd0, b} : 32'(b);
            2'b01:   return f3[2] ? {16'd0, h} : 32'(h);
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wd,
                                               input logic f3_half, input logic [1:0] lo);
        logic [31:0] m;
        m = word;
        if (f3_half) begin
            if (lo[1]) m[31:16] = wd;
            else       m[15:0]  = wd;
        end else begin
            m[{lo, 3'b000} +: 8] = wd[7:0];
        end
        return m;
    endfunction
`endif

    assign accept         = bus.req_valid & bus.req_ready;
    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_read   = (state == RD);
    assign bus.mem_write  = (state == WR);
    assign bus.mem_addr   = (state == IDLE) ? '0 : {word_addr_q, 2'b00};
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;

    // Unsigned-extend codes have no store form, so 100/101 with we=1 are rejected.
`ifdef LSU_SUBWORD_EN
    assign req_err = access_err(bus.req_funct3, bus.req_addr[1:0]) |
                     (bus.req_we & bus.req_funct3[2]);
`else
    assign req_err = access_err(bus.req_funct3, bus.req_addr[1:0]);
`endif

    // Request fields captured at accept; later req_* activity is ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_addr_q <= bus.req_addr[width-1:2];
            wdata_q     <= bus.req_wdata;
`ifdef LSU_SUBWORD_EN
            we_q        <= bus.req_we;
            funct3_q    <= bus.req_funct3;
            lo_q        <= bus.req_addr[1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
            mem_wdata_r  <= '0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= '0;
                        end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
                            mem_wdata_r <= bus.req_wdata;
                            state       <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
`ifdef LSU_SUBWORD_EN
                    if (we_q) begin
                        mem_wdata_r <= merge_lane(bus.mem_rdata, wdata_q[15:0], funct3_q[0], lo_q);
                        state       <= WR;
                    end else begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= extract_lane(bus.mem_rdata, funct3_q, lo_q);
                        state        <= IDLE;
                    end
`else
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= bus.mem_rdata;
                    state        <= IDLE;
`endif
                end
                WR: begin
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word behavioural data memory.
// Subword vectors are exercised when LSU_SUBWORD_EN is defined, error responses otherwise.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.width(32)) bus ();
    load_store_unit #(.width(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [0:15];
    logic        bk_we;
    logic [3:0]  bk_idx;
    logic [31:0] bk_data;

    always @(posedge clk) begin
        if (bk_we) mem[bk_idx] <= bk_data;
        else if (bus.mem_write) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[5:2]];
    end

    int checks = 0;
    int fails  = 0;
    int rc, nrd, nwr, wc, br, seen;
    logic [31:0] rd, wd, ra;
    logic er, r0;

    task automatic poke(input logic [3:0] idx, input logic [31:0] data);
        bk_we = 1'b1; bk_idx = idx; bk_data = data;
        @(posedge clk); #1;
        bk_we = 1'b0;
        @(negedge clk);
    endtask

    // Starts at a negedge, drives one request, and records strobes/response until the response.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata);
        rc = -1; rd = '0; er = 1'b0; nrd = 0; nwr = 0; wc = -1; wd = '0; ra = '0; br = 0;
        r0 = bus.req_ready;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_funct3 = 3'b111;
        bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'h5555_5555;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_read) begin nrd++; ra = bus.mem_addr; end
            if (bus.mem_write) begin nwr++; wc = k; wd = bus.mem_wdata; end
            if (bus.mem_read && bus.mem_write) nrd += 100;
            if (bus.resp_valid) begin rc = k; rd = bus.resp_rdata; er = bus.resp_err; break; end
            if (bus.req_ready) br++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
        checks++; if (bus.resp_err !== 1'b0) begin fails++; $display("FAIL rst_resp_err got=%b exp=0", bus.resp_err); end
        checks++; if (bus.resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata got=%h exp=0", bus.resp_rdata); end
        checks++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin fails++; $display("FAIL rst_strobes got=%b exp=00", {bus.mem_read, bus.mem_write}); end
        checks++; if (bus.mem_addr !== 32'h0) begin fails++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mem_wdata got=%h exp=0", bus.mem_wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_word();
        run_access(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (rc !== 3) begin fails++; $display("FAIL lw_cycle got=%0d exp=3", rc); end
        checks++; if (rd !== 32'h8000F0A5) begin fails++; $display("FAIL lw_rdata got=%h exp=8000f0a5", rd); end
        checks++; if (er !== 1'b0) begin fails++; $display("FAIL lw_err got=%b exp=0", er); end
        checks++; if (nrd !== 1 || nwr !== 0) begin fails++; $display("FAIL lw_strobes got=rd%0d/wr%0d exp=rd1/wr0", nrd, nwr); end
        checks++; if (ra !== 32'h10) begin fails++; $display("FAIL lw_mem_addr got=%h exp=10", ra); end
        checks++; if (br !== 0 || r0 !== 1'b1) begin fails++; $display("FAIL lw_ready got=busy%0d/idle%b exp=busy0/idle1", br, r0); end
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL lw_pulse got=%b exp=0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'h8000F0A5) begin fails++; $display("FAIL lw_hold got=%h exp=8000f0a5", bus.resp_rdata); end
        checks++; if (bus.mem_addr !== 32'h0) begin fails++; $display("FAIL idle_mem_addr got=%h exp=0", bus.mem_addr); end
        run_access(1'b0, 3'b010, 32'h14, 32'h0);
        checks++; if (rd !== 32'h0BADF00D || ra !== 32'h14) begin fails++; $display("FAIL lw14 got=%h@%h exp=0badf00d@14", rd, ra); end
    endtask

    task automatic test_store_word();
        run_access(1'b1, 3'b010, 32'h24, 32'h13579BDF);
        checks++; if (wc !== 1 || nwr !== 1 || nrd !== 0) begin fails++; $display("FAIL sw_strobe got=wc%0d/wr%0d/rd%0d exp=wc1/wr1/rd0", wc, nwr, nrd); end
        checks++; if (wd !== 32'h13579BDF) begin fails++; $display("FAIL sw_wdata got=%h exp=13579bdf", wd); end
        checks++; if (rc !== 2 || er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL sw_resp got=c%0d/e%b/%h exp=c2/e0/0", rc, er, rd); end
        checks++; if (mem[9] !== 32'h13579BDF) begin fails++; $display("FAIL sw_mem got=%h exp=13579bdf", mem[9]); end
        run_access(1'b0, 3'b010, 32'h24, 32'h0);
        checks++; if (rd !== 32'h13579BDF) begin fails++; $display("FAIL sw_readback got=%h exp=13579bdf", rd); end
    endtask

    task automatic test_errors();
        run_access(1'b0, 3'b010, 32'h12, 32'h0);
        checks++; if (rc !== 1 || er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL lw_mis got=c%0d/e%b/%h exp=c1/e1/0", rc, er, rd); end
        checks++; if (nrd !== 0 || nwr !== 0) begin fails++; $display("FAIL lw_mis_strobes got=rd%0d/wr%0d exp=0/0", nrd, nwr); end
        run_access(1'b1, 3'b010, 32'h22, 32'hFFFFFFFF);
        checks++; if (rc !== 1 || er !== 1'b1 || nwr !== 0) begin fails++; $display("FAIL sw_mis got=c%0d/e%b/wr%0d exp=c1/e1/wr0", rc, er, nwr); end
        checks++; if (mem[8] !== 32'h0) begin fails++; $display("FAIL sw_mis_mem got=%h exp=0", mem[8]); end
        run_access(1'b0, 3'b011, 32'h10, 32'h0);
        checks++; if (rc !== 1 || er !== 1'b1 || nrd !== 0) begin fails++; $display("FAIL reserved got=c%0d/e%b/rd%0d exp=c1/e1/rd0", rc, er, nrd); end
    endtask

    task automatic test_subword();
`ifdef LSU_SUBWORD_EN
        run_access(1'b0, 3'b000, 32'h10, 32'h0);
        checks++; if (rc !== 3 || rd !== 32'hFFFFFFA5 || er !== 1'b0) begin fails++; $display("FAIL lb got=c%0d/%h exp=c3/ffffffa5", rc, rd); end
        run_access(1'b0, 3'b100, 32'h11, 32'h0);
        checks++; if (rd !== 32'h000000F0) begin fails++; $display("FAIL lbu got=%h exp=000000f0", rd); end
        run_access(1'b0, 3'b001, 32'h12, 32'h0);
        checks++; if (rd !== 32'hFFFF8000 || nrd !== 1) begin fails++; $display("FAIL lh got=%h/rd%0d exp=ffff8000/rd1", rd, nrd); end
        run_access(1'b0, 3'b101, 32'h12, 32'h0);
        checks++; if (rd !== 32'h00008000 || nrd !== 1) begin fails++; $display("FAIL lhu got=%h/rd%0d exp=00008000/rd1", rd, nrd); end
        run_access(1'b0, 3'b001, 32'h11, 32'h0);
        checks++; if (rc !== 1 || er !== 1'b1) begin fails++; $display("FAIL lh_mis got=c%0d/e%b exp=c1/e1", rc, er); end
        run_access(1'b1, 3'b000, 32'h13, 32'h00000012);
        checks++; if (wc !== 3 || wd !== 32'h1200F0A5) begin fails++; $display("FAIL sb_write got=c%0d/%h exp=c3/1200f0a5", wc, wd); end
        checks++; if (rc !== 4 || er !== 1'b0 || nrd !== 1 || nwr !== 1) begin fails++; $display("FAIL sb_resp got=c%0d/e%b/rd%0d/wr%0d exp=c4/e0/1/1", rc, er, nrd, nwr); end
        run_access(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (rd !== 32'h1200F0A5) begin fails++; $display("FAIL sb_readback got=%h exp=1200f0a5", rd); end
        poke(4'd4, 32'h8000F0A5);
`else
        run_access(1'b0, 3'b000, 32'h10, 32'h0);
        checks++; if (rc !== 1 || er !== 1'b1 || nrd !== 0) begin fails++; $display("FAIL lb_nosub got=c%0d/e%b/rd%0d exp=c1/e1/rd0", rc, er, nrd); end
        run_access(1'b1, 3'b000, 32'h13, 32'h00000012);
        checks++; if (rc !== 1 || er !== 1'b1 || nwr !== 0 || nrd !== 0) begin fails++; $display("FAIL sb_nosub got=c%0d/e%b/wr%0d exp=c1/e1/wr0", rc, er, nwr); end
        run_access(1'b0, 3'b101, 32'h12, 32'h0);
        checks++; if (rc !== 1 || er !== 1'b1) begin fails++; $display("FAIL lhu_nosub got=c%0d/e%b exp=c1/e1", rc, er); end
        checks++; if (mem[4] !== 32'h8000F0A5) begin fails++; $display("FAIL nosub_mem got=%h exp=8000f0a5", mem[4]); end
`endif
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (rc !== 3 || rd !== 32'h8000F0A5) begin fails++; $display("FAIL b2b_load got=c%0d/%h exp=c3/8000f0a5", rc, rd); end
        run_access(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        checks++; if (r0 !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b exp=1", r0); end
        checks++; if (wc !== 1 || wd !== 32'hDEADBEEF || rc !== 2) begin fails++; $display("FAIL b2b_store got=wc%0d/%h/rc%0d exp=wc1/deadbeef/rc2", wc, wd, rc); end
        checks++; if (mem[8] !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_mem got=%h exp=deadbeef", mem[8]); end
    endtask

    task automatic test_reset_mid_op();
        run_access(1'b0, 3'b010, 32'h10, 32'h0);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.req_ready !== 1'b1 || bus.mem_addr !== 32'h0) begin fails++; $display("FAIL midrst_idle got=rdy%b/%h exp=rdy1/0", bus.req_ready, bus.mem_addr); end
        checks++; if (bus.resp_rdata !== 32'h0 || bus.mem_wdata !== 32'h0) begin fails++; $display("FAIL midrst_data got=%h/%h exp=0/0", bus.resp_rdata, bus.mem_wdata); end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_read || bus.mem_write) seen++;
        end
        checks++; if (seen !== 0) begin fails++; $display("FAIL midrst_quiet got=%0d exp=0", seen); end
`ifdef LSU_SUBWORD_EN
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h0000BEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_write) seen++;
        end
        checks++; if (seen !== 0 || bus.req_ready !== 1'b1) begin fails++; $display("FAIL sh_rst got=%0d/rdy%b exp=0/rdy1", seen, bus.req_ready); end
        checks++; if (mem[4] !== 32'h8000F0A5) begin fails++; $display("FAIL sh_rst_mem got=%h exp=8000f0a5", mem[4]); end
`endif
    endtask

    initial begin
        rst = 1'b1; bk_we = 1'b0; bk_idx = '0; bk_data = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = '0; bus.req_wdata = '0;
        @(negedge clk);
        test_reset();
        poke(4'd4, 32'h8000F0A5);
        poke(4'd5, 32'h0BADF00D);
        poke(4'd8, 32'h0);
        poke(4'd9, 32'h0);
        test_load_word();
        test_store_word();
        test_errors();
        test_subword();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: width, 32, address/data width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_ready  output  1  LSU accepts a request; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I size code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 req_addr  input  width  byte address.
REQ-009 req_wdata  input  width  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  width  load result, extended per funct3; 0 for stores and errors.
REQ-012 resp_err  output  1  qualifies resp_valid: misaligned or unsupported access.
REQ-013 mem_addr  output  width  word address {req_addr[31:2],2'b00}; 0 in IDLE.
REQ-014 mem_read  output  1  read strobe to data memory.
REQ-015 mem_write  output  1  write strobe to data memory, full word.
REQ-016 mem_wdata  output  width  word written to memory.
REQ-017 mem_rdata  input  width  memory read data, registered, valid the cycle after mem_read.

Function
REQ-018 FSM states: IDLE, RD (mem_read=1), CAP (mem_rdata valid), WR (mem_write=1); mem strobes are decoded from state only.
REQ-019 Accept = req_valid & req_ready at a clock edge; all req_* fields are latched then, and later changes are ignored.
REQ-020 Misaligned accesses are errors: W with addr[1:0]!=0; H/HU with addr[0]=1. Reserved funct3 values are also errors.
REQ-021 Error path: IDLE->IDLE with no memory strobe; resp_valid=1 and resp_err=1 in the cycle after accept.
REQ-022 Load: IDLE->RD->CAP->IDLE; at the CAP exit edge, resp_rdata takes the extracted lane and resp_valid=1 in the next cycle (accept cycle 0, resp cycle 3).
REQ-023 Extraction: the byte lane is selected by addr[1:0] and the half lane by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-024 SW: IDLE->WR->IDLE; mem_wdata=req_wdata; resp_valid in cycle 2.
REQ-025 SB/SH read-modify-write: IDLE->RD->CAP->WR->IDLE; CAP merges req_wdata[7:0]/[15:0] into the addressed lane of mem_rdata; resp_valid in cycle 4.
REQ-026 mem_read and mem_write are never high in the same cycle; each is high for exactly one cycle per access.
REQ-027 req_ready=1 in the cycle resp_valid=1, so back-to-back requests are allowed; requests during RD/CAP/WR are not accepted.
REQ-028 resp_valid has no backpressure; resp_rdata and resp_err hold until the next response.

Reset
REQ-029 When rst=1 at an edge: state=IDLE; req_ready=1; resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr and mem_wdata all =0.
REQ-030 Reset mid-operation abandons the access: an RMW in RD/CAP issues no write, and no resp_valid is produced.

Configuration
REQ-031 Macro LSU_SUBWORD_EN defined: all funct3 codes in REQ-007 are supported.
REQ-032 Macro LSU_SUBWORD_EN undefined: only funct3=010 is legal and all others return resp_err; the RMW path and extraction logic are not built.

Verification
REQ-033 Word 0x10=0x8000F0A5; LB 0x10 -> resp_rdata=0xFFFFFFA5 in cycle 3; LBU 0x11 -> 0x000000F0.
REQ-034 Same word; LH 0x12 -> 0xFFFF8000; LHU 0x12 -> 0x00008000; one mem_read each.
REQ-035 SB 0x13 with wdata 0x12 -> mem_write in cycle 3 with mem_wdata=0x1200F0A5, resp_valid in cycle 4; LW 0x10 then returns 0x1200F0A5.
REQ-036 LW 0x12 -> resp_err=1 in cycle 1; mem_read and mem_write stay 0.
REQ-037 SH 0x10 with wdata 0xBEEF, rst=1 during CAP -> no mem_write, no resp_valid, word unchanged, req_ready=1 after reset.
REQ-038 SW 0x20 with 0xDEADBEEF accepted in the resp_valid cycle of a prior load -> mem_write in the next cycle; without LSU_SUBWORD_EN, LB 0x10 -> resp_err=1.
